// File: rtl/debounce_pulse.sv
// debounce_pulse: 2-flop synchronizer plus stability-qualified FSM producing a clean level and change strobes.
// Optional DEBOUNCE_GLITCH_CNT_EN adds a saturating glitch_count output counting aborted qualifications.
module debounce_pulse #(
   parameter int STABLE_CYCLES = 4,
   parameter int CNT_W         = 16,
   parameter bit RESET_LEVEL   = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       din,
`ifdef DEBOUNCE_GLITCH_CNT_EN
   output logic [7:0] glitch_count,
`endif
   output logic       level,
   output logic       rise_pulse,
   output logic       fall_pulse,
   output logic       chg_pulse
);
   typedef enum logic [1:0] {STABLE_LO, CHK_HI, STABLE_HI, CHK_LO} state_t;
   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              s1_q, s2_q;
   logic              level_q, level_d;
   logic              rise_q, rise_d, fall_q, fall_d, chg_q;
   logic              done;
   assign done = cnt_q == CNT_W'(STABLE_CYCLES);
   always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      level_d = level_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      case (state_q)
         STABLE_LO: if (s2_q) begin
            state_d = CHK_HI;
            cnt_d   = CNT_W'(1);
         end
         CHK_HI: if (!s2_q) state_d = STABLE_LO;
            else if (done) begin
               state_d = STABLE_HI;
               level_d = 1'b1;
               rise_d  = 1'b1;
            end else cnt_d = cnt_q + CNT_W'(1);
         STABLE_HI: if (!s2_q) begin
            state_d = CHK_LO;
            cnt_d   = CNT_W'(1);
         end
         default: if (s2_q) state_d = STABLE_HI;
            else if (done) begin
               state_d = STABLE_LO;
               level_d = 1'b0;
               fall_d  = 1'b1;
            end else cnt_d = cnt_q + CNT_W'(1);
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q    <= RESET_LEVEL;
         s2_q    <= RESET_LEVEL;
         state_q <= RESET_LEVEL ? STABLE_HI : STABLE_LO;
         cnt_q   <= '0;
         level_q <= RESET_LEVEL;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
         chg_q   <= 1'b0;
      end else begin
         s1_q    <= din;
         s2_q    <= s1_q;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         chg_q   <= rise_d | fall_d;
      end
   end
`ifdef DEBOUNCE_GLITCH_CNT_EN
   logic [7:0] gcnt_q;
   logic       abort;
   assign abort = (state_q == CHK_HI && !s2_q) || (state_q == CHK_LO && s2_q);
   always_ff @(posedge clk) begin
      if (rst) gcnt_q <= '0;
      else if (abort && gcnt_q != 8'hff) gcnt_q <= gcnt_q + 8'd1;
   end
   assign glitch_count = gcnt_q;
`endif
   assign level      = level_q;
   assign rise_pulse = rise_q;
   assign fall_pulse = fall_q;
   assign chg_pulse  = chg_q;
endmodule

// File: tb/tb_debounce_pulse.sv
// tb_debounce_pulse: directed plus random stimulus checked against a run-length reference model of the debouncer.
module tb_debounce_pulse;
   localparam int S = 4;
   logic clk = 1'b0, rst = 1'b1, din = 1'b0;
   logic level, rise_pulse, fall_pulse, chg_pulse;
`ifdef DEBOUNCE_GLITCH_CNT_EN
   logic [7:0] glitch_count;
`endif
   int n_assert = 0, n_fail = 0;
   logic m_s1 = 0, m_s2 = 0, m_level = 0, m_rise = 0, m_fall = 0;
   int m_run = 0, m_gc = 0;
   logic cap_q = 0;
   int n_cap = 0;

   debounce_pulse #(.STABLE_CYCLES(S), .CNT_W(16), .RESET_LEVEL(1'b0)) dut (
      .clk(clk), .rst(rst), .din(din),
`ifdef DEBOUNCE_GLITCH_CNT_EN
      .glitch_count(glitch_count),
`endif
      .level(level), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse), .chg_pulse(chg_pulse));

   always #5 clk = ~clk;

   // downstream enabled flop: data = level, enable = chg_pulse
   always @(posedge clk) if (chg_pulse) begin
      cap_q <= level;
      n_cap <= n_cap + 1;
   end

   task automatic check(input string tag, input int got, input int exp);
      n_assert++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Reference: the level flips once the synchronized input has disagreed with it
   // for S+1 consecutive edges; any agreement in between restarts the run.
   task automatic model_edge(input logic d, input logic r);
      if (r) begin
         m_s1 = 0; m_s2 = 0; m_level = 0; m_run = 0; m_rise = 0; m_fall = 0; m_gc = 0;
      end else begin
         m_rise = 0; m_fall = 0;
         if (m_s2 != m_level) begin
            m_run++;
            if (m_run == S + 1) begin
               m_level = m_s2;
               m_rise = m_level;
               m_fall = !m_level;
               m_run = 0;
            end
         end else begin
            if (m_run > 0 && m_gc < 255) m_gc++;
            m_run = 0;
         end
         m_s2 = m_s1;
         m_s1 = d;
      end
   endtask

   task automatic step(input logic d, input logic r);
      din = d;
      rst = r;
      @(posedge clk);
      model_edge(d, r);
      #1;
      check("level", int'(level), int'(m_level));
      check("rise_pulse", int'(rise_pulse), int'(m_rise));
      check("fall_pulse", int'(fall_pulse), int'(m_fall));
      check("chg_pulse", int'(chg_pulse), int'(m_rise | m_fall));
      check("rise_fall_excl", int'(rise_pulse & fall_pulse), 0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
      check("glitch_count", int'(glitch_count), m_gc);
`endif
   endtask

   // hold din for n edges; report edges from first sample to first pulse of the kind wanted
   task automatic hold(input logic d, input int n, input bit want_rise, output int lat, output int npulse);
      lat = -1;
      npulse = 0;
      for (int i = 0; i < n; i++) begin
         step(d, 1'b0);
         if (want_rise ? rise_pulse : fall_pulse) begin
            if (lat < 0) lat = i;
            npulse++;
         end
      end
   endtask

   initial begin
      int lat, np, caps;
      for (int i = 0; i < 3; i++) step(i[0], 1'b1);
      step(1'b0, 1'b0);
      check("reset_level", int'(level), 0);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
      // clean rise
      hold(1'b1, 10, 1'b1, lat, np);
      check("rise_latency", lat, S + 2);
      check("rise_count", np, 1);
      check("rise_level", int'(level), 1);
      // glitch low for three synchronized cycles from level 1
      hold(1'b0, 3, 1'b0, lat, np);
      hold(1'b1, 8, 1'b0, lat, np);
      check("glitch_no_fall", np, 0);
      check("glitch_level", int'(level), 1);
      // fall with downstream capture
      caps = n_cap;
      hold(1'b0, 10, 1'b0, lat, np);
      check("fall_latency", lat, S + 2);
      check("fall_count", np, 1);
      #5;
      check("cap_after_fall", int'(cap_q), 0);
      check("cap_count_fall", n_cap - caps, 1);
      // bounce then settle
      caps = n_cap;
      for (int k = 0; k < 2; k++) begin
         hold(1'b1, 2, 1'b1, lat, np);
         check("bounce_no_rise_hi", np, 0);
         hold(1'b0, 2, 1'b1, lat, np);
         check("bounce_no_rise_lo", np, 0);
      end
      hold(1'b1, 8, 1'b1, lat, np);
      check("settle_latency", lat, S + 2);
      check("settle_count", np, 1);
      #5;
      check("cap_after_rise", int'(cap_q), 1);
      check("cap_count_rise", n_cap - caps, 1);
      // reset mid-qualification
      hold(1'b0, 10, 1'b0, lat, np);
      hold(1'b1, 4, 1'b1, lat, np);
      check("pre_reset_no_rise", np, 0);
      step(1'b1, 1'b1);
      check("reset_mid_pulse", int'(chg_pulse), 0);
      hold(1'b1, 10, 1'b1, lat, np);
      check("post_reset_latency", lat, S + 2);
      check("post_reset_count", np, 1);
      // random runs with occasional reset
      for (int r = 0; r < 150; r++) begin
         logic d;
         int len;
         d = 1'($urandom);
         len = int'($urandom_range(1, 9));
         for (int i = 0; i < len; i++) step(d, $urandom_range(0, 99) == 0);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end
endmodule
